// File: rtl/pwm_robot.sv
// Four-channel PWM generator fed from the robot IO register block.
// Optional macro PWM_SHADOW_EN: duty writes are held and applied at the period wrap.
module pwm_robot #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr,
    input  logic [31:0]         cfg_data,
    input  logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic                update_pending
);

    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [7:0]      CNT_LAST = 8'd254;

    logic [PRE_W-1:0]             pre_r;
    logic [7:0]                   cnt_r;
    logic                         tick_s;
    logic                         wrap_s;
    logic [CHANNELS-1:0]          raw_s;
    logic [CHANNELS-1:0][7:0]     cfg_duty_s;
    logic [CHANNELS-1:0][7:0]     duty_act_r;

    // Bytes above the configured channel count are simply never unpacked.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign cfg_duty_s[g] = cfg_data[8*g +: 8];
    end

    // Tick and wrap decode plus per-channel compare.
    always_comb begin
        tick_s = 1'b0;
        wrap_s = 1'b0;
        raw_s  = '0;
        if (pre_r == PRE_LAST) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (tick_s && (cnt_r == CNT_LAST)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            raw_s[i] = (cnt_r < duty_act_r[i]);
        end
    end

    // Prescaler: one counter tick every PRESCALE clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Period counter runs 0..254 so duty 255 stays high for the whole period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (wrap_s) begin
            cnt_r <= 8'd0;
        end else if (tick_s) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [CHANNELS-1:0][7:0] duty_pend_r;
    logic                     pending_r;

    // Shadow update: a write coinciding with the wrap bypasses the pending stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act_r  <= '0;
            duty_pend_r <= '0;
            pending_r   <= 1'b0;
        end else if (cfg_wr && wrap_s) begin
            duty_act_r  <= cfg_duty_s;
            duty_pend_r <= cfg_duty_s;
            pending_r   <= 1'b0;
        end else if (cfg_wr) begin
            duty_pend_r <= cfg_duty_s;
            pending_r   <= 1'b1;
        end else if (wrap_s && pending_r) begin
            duty_act_r  <= duty_pend_r;
            pending_r   <= 1'b0;
        end else begin
            pending_r   <= pending_r;
        end
    end

    assign update_pending = pending_r;
`else
    // Direct update: the new duty applies mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act_r <= '0;
        end else if (cfg_wr) begin
            duty_act_r <= cfg_duty_s;
        end else begin
            duty_act_r <= duty_act_r;
        end
    end

    assign update_pending = 1'b0;
`endif

    // Registered outputs; a disabled channel is masked but keeps counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= raw_s & en;
            period_tick <= wrap_s;
        end
    end

endmodule

// File: tb/tb_pwm_robot.sv
// Self-checking bench for pwm_robot: directed period measurements plus random
// stimulus compared each cycle against a position-based reference model.
module tb_pwm_robot;

    localparam int CH  = 4;
    localparam int PRE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [31:0]   cfg_data = 32'd0;
    logic [CH-1:0] en = '0;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic          update_pending;

    pwm_robot #(.CHANNELS(CH), .PRESCALE(PRE)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_data(cfg_data), .en(en),
        .pwm_out(pwm_out), .period_tick(period_tick), .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference model: position in the period is derived from edges since reset.
    int            n;
    int            act [CH];
`ifdef PWM_SHADOW_EN
    int            pend [CH];
`endif
    bit            pend_v;
    logic [CH-1:0] exp_pwm;
    logic          exp_tick;
    logic          exp_upd;
    int            hi [CH];
    int            ticks_seen;
    localparam bit SHADOW =
`ifdef PWM_SHADOW_EN
        1'b1;
`else
        1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pos();
        return (n / PRE) % 255;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < CH; i++) begin
            act[i] = 0;
`ifdef PWM_SHADOW_EN
            pend[i] = 0;
`endif
        end
        pend_v   = 1'b0;
        exp_pwm  = '0;
        exp_tick = 1'b0;
        exp_upd  = 1'b0;
    endtask

    task automatic clear_hi();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        ticks_seen = 0;
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare at negedge.
    task automatic step();
        int c;
        bit wrap;
        c    = pos();
        wrap = ((n % PRE) == PRE - 1) && (c == 254);
        for (int i = 0; i < CH; i++) exp_pwm[i] = (c < act[i]) && en[i];
        exp_tick = wrap;
`ifdef PWM_SHADOW_EN
        if (cfg_wr) begin
            for (int i = 0; i < CH; i++) pend[i] = int'(cfg_data[8*i +: 8]);
            if (wrap) begin
                for (int i = 0; i < CH; i++) act[i] = pend[i];
                pend_v = 1'b0;
            end else begin
                pend_v = 1'b1;
            end
        end else if (wrap && pend_v) begin
            for (int i = 0; i < CH; i++) act[i] = pend[i];
            pend_v = 1'b0;
        end
`else
        if (cfg_wr) begin
            for (int i = 0; i < CH; i++) act[i] = int'(cfg_data[8*i +: 8]);
        end
`endif
        exp_upd = pend_v;
        n++;
        @(posedge clk);
        @(negedge clk);
        cfg_wr = 1'b0;
        check_eq("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check_eq("period_tick", 32'(period_tick), 32'(exp_tick));
        check_eq("update_pending", 32'(update_pending), 32'(exp_upd));
        for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
        ticks_seen += int'(period_tick);
    endtask

    task automatic run_steps(input int k);
        repeat (k) step();
    endtask

    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while (pos() != p && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic write(input logic [31:0] d);
        cfg_wr   = 1'b1;
        cfg_data = d;
    endtask

    initial begin
        int k;
        model_reset();
        clear_hi();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("rst_tick", 32'(period_tick), 32'd0);
        check_eq("rst_upd", 32'(update_pending), 32'd0);
        rst = 1'b0;

        // Idle: duty 0 keeps outputs low whatever the enables.
        en = 4'($urandom);
        run_steps(600);
        check_eq("idle_ticks", 32'(ticks_seen), 32'd2);
        check_eq("idle_high", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);

        // Four-duty pattern.
        en = 4'hF;
        run_to(100);
        write(32'hFF80_0100);
        step();
        run_to(0);
        clear_hi();
        run_steps(255);
        check_eq("pat_ch0", 32'(hi[0]), 32'd0);
        check_eq("pat_ch1", 32'(hi[1]), 32'd1);
        check_eq("pat_ch2", 32'(hi[2]), 32'd128);
        check_eq("pat_ch3", 32'(hi[3]), 32'd255);

        // Mid-period write 0x40 over active 0x10.
        write(32'h0000_0010);
        step();
        run_to(0);
        clear_hi();
        run_to(20);
        write(32'h0000_0040);
        step();
        check_eq("mid_upd_rise", 32'(update_pending), SHADOW ? 32'd1 : 32'd0);
        step();
        check_eq("mid_vis", 32'(pwm_out[0]), SHADOW ? 32'd0 : 32'd1);
        run_to(0);
        check_eq("mid_cur_hi", 32'(hi[0]), SHADOW ? 32'd16 : 32'd59);
        check_eq("mid_upd_clr", 32'(update_pending), 32'd0);
        check_eq("mid_tick", 32'(period_tick), 32'd1);
        clear_hi();
        run_steps(255);
        check_eq("mid_next_hi", 32'(hi[0]), 32'd64);

        // Two writes in one period: last wins.
        clear_hi();
        run_to(30);
        write(32'h0000_0020);
        step();
        run_to(60);
        write(32'h0000_0060);
        step();
        run_to(0);
        check_eq("two_cur_hi", 32'(hi[0]), SHADOW ? 32'd64 : 32'd67);
        clear_hi();
        run_steps(255);
        check_eq("two_next_hi", 32'(hi[0]), 32'd96);

        // Write coincident with the wrap.
        run_to(254);
        write(32'h0000_0005);
        step();
        check_eq("wrapwr_upd", 32'(update_pending), 32'd0);
        check_eq("wrapwr_tick", 32'(period_tick), 32'd1);
        clear_hi();
        run_steps(255);
        check_eq("wrapwr_hi", 32'(hi[0]), 32'd5);
        run_to(2);
        check_eq("en_pre", 32'(pwm_out[0]), 32'd1);
        en[0] = 1'b0;
        step();
        check_eq("en_drop", 32'(pwm_out[0]), 32'd0);

        // Reset mid-period with a write pending.
        en = 4'hF;
        write(32'h7777_7777);
        step();
        check_eq("pre_rst_pwm", 32'(pwm_out[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_pwm", 32'(pwm_out), 32'd0);
        check_eq("async_tick", 32'(period_tick), 32'd0);
        check_eq("async_upd", 32'(update_pending), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_hi();
        k = 0;
        do begin
            step();
            k++;
        end while (!period_tick && k < 600);
        check_eq("rst_first_tick", 32'(k), 32'd255);
        check_eq("rst_duty0", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);

        // Random traffic against the model.
        repeat (1500) begin
            if ($urandom_range(0, 49) == 0) en = 4'($urandom);
            if ($urandom_range(0, 59) == 0) write($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
